dual_fetch_queue: RTL and testbench

- Circular instruction buffer between fetch and the dual-issue decode stage.
- Accepts up to two instruction/PC pairs per cycle from fetch and presents the two oldest entries as decode slot 0 (older) and slot 1 (younger).
- Slot outputs feed the decode control and immediate-extension logic of the two issue lanes.
- Absorbs rate mismatch when decode consumes 0, 1 or 2 instructions per cycle; flushes on redirect.

---
 rtl/dual_fetch_queue.sv | 82 ++++++++
 tb/tb_dual_fetch_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: circular fetch-to-decode buffer, two in / two out per cycle.
// Optional same-cycle bypass through an empty queue: DUAL_FETCH_QUEUE_BYPASS_EN.
module dual_fetch_queue #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     f_valid0,
   input  logic                     f_valid1,
   input  logic [31:0]              f_instr0,
   input  logic [31:0]              f_instr1,
   input  logic [31:0]              f_pc0,
   input  logic [31:0]              f_pc1,
   output logic                     f_ready,
   output logic                     d_valid0,
   output logic                     d_valid1,
   output logic [31:0]              d_instr0,
   output logic [31:0]              d_instr1,
   output logic [31:0]              d_pc0,
   output logic [31:0]              d_pc1,
   input  logic [1:0]               d_take,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];
   logic [AW-1:0] wp, rp, rp1;
   logic [1:0]    n_in, n_out, n_wr, n_rd, avail;
   logic          byp;
   logic [31:0]   w_instr0, w_pc0;
   // Acceptance, slot presentation, consumption and write-pointer bookkeeping.
   always_comb begin
      f_ready  = count <= CW'(DEPTH - 2);
      n_in     = (f_ready && f_valid0) ? (f_valid1 ? 2'd2 : 2'd1) : 2'd0;
      rp1      = rp + 1'b1;
`ifdef DUAL_FETCH_QUEUE_BYPASS_EN
      byp      = (count == '0) && !flush && !reset;
`else
      byp      = 1'b0;
`endif
      d_valid0 = byp ? (f_valid0 & f_ready) : (count != '0);
      d_valid1 = byp ? (f_valid0 & f_valid1 & f_ready) : (count >= CW'(2));
      d_instr0 = !d_valid0 ? 32'd0 : byp ? f_instr0 : mem_instr[rp];
      d_pc0    = !d_valid0 ? 32'd0 : byp ? f_pc0    : mem_pc[rp];
      d_instr1 = !d_valid1 ? 32'd0 : byp ? f_instr1 : mem_instr[rp1];
      d_pc1    = !d_valid1 ? 32'd0 : byp ? f_pc1    : mem_pc[rp1];
      avail    = {1'b0, d_valid0} + {1'b0, d_valid1};
      n_out    = (d_take > avail) ? avail : d_take;
      // Bypassed entries taken by decode never touch storage; the rest land in order.
      n_wr     = byp ? n_in - n_out : n_in;
      n_rd     = byp ? 2'd0 : n_out;
      w_instr0 = (byp && n_out == 2'd1) ? f_instr1 : f_instr0;
      w_pc0    = (byp && n_out == 2'd1) ? f_pc1    : f_pc0;
   end
   // Pointer and occupancy state; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(n_wr);
         rp    <= rp + AW'(n_rd);
         count <= count + CW'(n_in) - CW'(n_out);
      end
   end
   // Entry storage; contents are never cleared, outputs are masked by valid.
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         if (n_wr != 2'd0) begin
            mem_instr[wp] <= w_instr0;
            mem_pc[wp]    <= w_pc0;
         end
         if (n_wr == 2'd2) begin
            mem_instr[wp + 1'b1] <= f_instr1;
            mem_pc[wp + 1'b1]    <= f_pc1;
         end
      end
   end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb_dual_fetch_queue: random + directed scoreboard bench for dual_fetch_queue.
module tb_dual_fetch_queue;
   localparam int DEPTH = 8;
   typedef struct packed {
      logic        rst, fl, v0, v1;
      logic [31:0] i0, p0, i1, p1;
      logic [1:0]  take;
   } stim_t;
   typedef struct packed {
      logic [31:0] i, p;
   } ent_t;
   logic        clk = 0, reset = 1, flush = 0, f_valid0 = 0, f_valid1 = 0;
   logic [31:0] f_instr0 = 0, f_instr1 = 0, f_pc0 = 0, f_pc1 = 0;
   logic        f_ready, d_valid0, d_valid1;
   logic [31:0] d_instr0, d_instr1, d_pc0, d_pc1;
   logic [1:0]  d_take = 0;
   logic [$clog2(DEPTH):0] count;
   stim_t sq[$];
   ent_t  mq[$];
   int    total = 0, bad = 0;
   logic [31:0] pc = 0;

   dual_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .f_valid0(f_valid0), .f_valid1(f_valid1),
      .f_instr0(f_instr0), .f_instr1(f_instr1), .f_pc0(f_pc0), .f_pc1(f_pc1),
      .f_ready(f_ready), .d_valid0(d_valid0), .d_valid1(d_valid1),
      .d_instr0(d_instr0), .d_instr1(d_instr1), .d_pc0(d_pc0), .d_pc1(d_pc1),
      .d_take(d_take), .count(count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic drive(input logic r, fl, v0, v1, input logic [31:0] i0, p0, i1, p1,
                        input logic [1:0] tk);
      @(posedge clk);
      #1;
      reset = r; flush = fl; f_valid0 = v0; f_valid1 = v1;
      f_instr0 = i0; f_pc0 = p0; f_instr1 = i1; f_pc1 = p1; d_take = tk;
      sq.push_back('{r, fl, v0, v1, i0, p0, i1, p1, tk});
   endtask

   task automatic idle(input logic [1:0] tk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, tk);
   endtask

   task automatic fetch(input logic v0, v1, input logic [1:0] tk);
      drive(0, 0, v0, v1, $urandom, pc, $urandom, pc + 4, tk);
      pc = pc + 8;
   endtask

   // Monitor: pops the beat applied this cycle, checks outputs, then advances the model.
   initial begin
      forever begin
         @(posedge clk);
         #4;
         if (sq.size() > 0) begin
            stim_t s;
            ent_t  a, b;
            int    n, k, nout;
            logic  e0, e1, byp;
            s   = sq.pop_front();
            n   = mq.size();
            byp = 0;
`ifdef DUAL_FETCH_QUEUE_BYPASS_EN
            byp = (n == 0) && !s.rst && !s.fl;
`endif
            a = '0;
            b = '0;
            if (byp) begin
               e0 = s.v0;
               e1 = s.v0 & s.v1;
               if (e0) a = '{s.i0, s.p0};
               if (e1) b = '{s.i1, s.p1};
            end else begin
               e0 = n >= 1;
               e1 = n >= 2;
               if (e0) a = mq[0];
               if (e1) b = mq[1];
            end
            chk("count", 32'(count), 32'(n));
            chk("f_ready", 32'(f_ready), 32'(n <= DEPTH - 2));
            chk("d_valid0", 32'(d_valid0), 32'(e0));
            chk("d_valid1", 32'(d_valid1), 32'(e1));
            chk("d_instr0", d_instr0, a.i);
            chk("d_pc0", d_pc0, a.p);
            chk("d_instr1", d_instr1, b.i);
            chk("d_pc1", d_pc1, b.p);
            if (s.rst || s.fl) mq.delete();
            else begin
               if (n <= DEPTH - 2 && s.v0) begin
                  mq.push_back('{s.i0, s.p0});
                  if (s.v1) mq.push_back('{s.i1, s.p1});
               end
               k    = int'(e0) + int'(e1);
               nout = (int'(s.take) < k) ? int'(s.take) : k;
               repeat (nout) void'(mq.pop_front());
            end
         end
      end
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 1, 2, 3, 4, 2);
      idle(0);
      idle(2);
      repeat (5) drive(0, 0, 1, 1, 32'h00000013, 32'h0, 32'h00100093, 32'h4, 0);
      idle(1);
      idle(2);
      idle(2);
      pc = 32'h100;
      repeat (12) fetch(1, 1, 1);
      repeat (6) idle(2);
      fetch(1, 1, 0);
      fetch(1, 0, 0);
      drive(0, 1, 1, 1, 32'h11, 32'h200, 32'h22, 32'h204, 2);
      idle(0);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      fetch(1, 0, 0);
      idle(2);
      idle(0);
      fetch(0, 1, 0);
      idle(1);
      fetch(1, 1, 1);
      drive(1, 1, 1, 1, 5, 6, 7, 8, 2);
      idle(0);
      for (int i = 0; i < 3000; i++) begin
         logic r, fl, v0, v1;
         r  = $urandom_range(0, 63) == 0;
         fl = $urandom_range(0, 15) == 0;
         v0 = $urandom_range(0, 3) != 0;
         v1 = $urandom_range(0, 1) == 1;
         drive(r, fl, v0, v1, $urandom, pc, $urandom, pc + 4, 2'($urandom_range(0, 2)));
         pc = pc + 8;
      end
      idle(0);
      repeat (3) @(posedge clk);
      #6;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
